// File: rtl/nn_sched_pkg.sv
// Shared state encoding, counter width and default timing for the nn request scheduler.
package nn_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t LOAD_KICK = 3'd0;
  localparam state_t LOAD_WAIT = 3'd1;
  localparam state_t IDLE      = 3'd2;
  localparam state_t ISSUE     = 3'd3;
  localparam state_t WAIT      = 3'd4;
  localparam state_t RESPOND   = 3'd5;
  localparam state_t GAP       = 3'd6;

  localparam int CNT_W = 8;

  localparam int DEF_NN_LATENCY  = 6;
  localparam int DEF_LOAD_CYCLES = 9;
  localparam int DEF_GAP_CYCLES  = 2;

endpackage

// File: rtl/nn_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping to 0.
module nn_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_req_scheduler.sv
// Time-shares one nn datapath between NUM_REQ requesters with round-robin grant and tagged responses.
// Optional NN_SCHED_STATS_EN adds saturating response/overflow counters (stat_done, stat_ovf).
module nn_req_scheduler
  import nn_sched_pkg::*;
#(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_REQ     = 4,
  parameter int NN_LATENCY  = DEF_NN_LATENCY,
  parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_in2,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic [DATAWIDTH-1:0]           rsp_data,
  output logic                           rsp_ovf,
  output logic                           rsp_zero,
  output logic                           busy,
  output logic                           nn_resetn,
  output logic                           nn_enable,
  output logic [DATAWIDTH-1:0]           nn_input_1,
  output logic [DATAWIDTH-1:0]           nn_input_2,
  input  logic [DATAWIDTH-1:0]           nn_final_output,
  input  logic                           nn_total_ovf,
`ifdef NN_SCHED_STATS_EN
  output logic [15:0]                    stat_done,
  output logic [15:0]                    stat_ovf,
`endif
  input  logic                           nn_total_zero
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [ID_W-1:0]        ptr_reg;
  logic [ID_W-1:0]        op_id_reg;
  logic [DATAWIDTH-1:0]   in1_reg;
  logic [DATAWIDTH-1:0]   in2_reg;
  logic                   rsp_valid_reg;
  logic [ID_W-1:0]        rsp_id_reg;
  logic [DATAWIDTH-1:0]   rsp_data_reg;
  logic                   rsp_ovf_reg;
  logic                   rsp_zero_reg;

  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic                   take_req;

  nn_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign take_req  = (state_reg == IDLE) && grant_any;
  assign req_ready = (state_reg == IDLE) ? grant : '0;
  assign busy      = (state_reg != IDLE);
  assign nn_resetn = ~reset;
  // Gated by reset so the kick state's enable stays low while reset is held.
  assign nn_enable = ~reset && ((state_reg == LOAD_KICK) || (state_reg == ISSUE));

  assign nn_input_1 = in1_reg;
  assign nn_input_2 = in2_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_ovf    = rsp_ovf_reg;
  assign rsp_zero   = rsp_zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= LOAD_KICK;
      cnt_reg       <= '0;
      ptr_reg       <= '0;
      op_id_reg     <= '0;
      in1_reg       <= '0;
      in2_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
      rsp_ovf_reg   <= 1'b0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        LOAD_KICK: begin
          state_reg <= LOAD_WAIT;
          cnt_reg   <= '0;
        end
        LOAD_WAIT: begin
          if (cnt_reg == CNT_W'(LOAD_CYCLES)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (take_req) begin
            in1_reg   <= req_in1[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
            in2_reg   <= req_in2[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
            op_id_reg <= grant_idx;
            ptr_reg   <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
          cnt_reg   <= '0;
        end
        WAIT: begin
          // The edge after NN_LATENCY-1 counted edges is where nn results are sampled.
          if (cnt_reg == CNT_W'(NN_LATENCY-1)) begin
            rsp_data_reg  <= nn_final_output;
            rsp_ovf_reg   <= nn_total_ovf;
            rsp_zero_reg  <= nn_total_zero;
            rsp_id_reg    <= op_id_reg;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESPOND;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= GAP;
            cnt_reg       <= '0;
          end
        end
        GAP: begin
          if (cnt_reg == CNT_W'(GAP_CYCLES-1)) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= LOAD_KICK;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

`ifdef NN_SCHED_STATS_EN
  logic [15:0] stat_done_reg;
  logic [15:0] stat_ovf_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_done_reg <= '0;
      stat_ovf_reg  <= '0;
    end else if (rsp_valid_reg && rsp_ready) begin
      if (stat_done_reg != 16'hFFFF) stat_done_reg <= stat_done_reg + 16'd1;
      if (rsp_ovf_reg && (stat_ovf_reg != 16'hFFFF)) stat_ovf_reg <= stat_ovf_reg + 16'd1;
    end
  end

  assign stat_done = stat_done_reg;
  assign stat_ovf  = stat_ovf_reg;
`endif

endmodule
